msg_frame_assembler: RTL
========================

// Module: msg_frame_assembler
// PURPOSE
//  Byte-serial front end of the cipher datapath. Collects a stream of ASCII bytes
//  over a valid/ready handshake into one MSG_LEN-byte parallel frame. The frame is
//  the input array of the combinational encrypt stage. Short messages are closed
//  early by in_last and padded with PAD_BYTE. The frame is held stable until
//  consumed by the downstream handshake.
// PARAMETERS
//  MSG_LEN   9      bytes per frame (>=2); width of frame_out array
//  PAD_BYTE  8'h20  fill value for unused slots of a short frame (ASCII space)
// PORTS
//  clk          in   1                single clock; all state on posedge
//  rst          in   1                synchronous, active-high reset
//  in_byte      in   8                incoming message byte
//  in_valid     in   1                in_byte valid
//  in_last      in   1                qualifies in_byte as final byte of message
//  in_ready     out  1                assembler accepts a byte this cycle
//  frame_out    out  8 x [0:MSG_LEN-1] unpacked byte array to encrypt.text_in
//  frame_len    out  $clog2(MSG_LEN+1) number of real (non-pad) bytes, 1..MSG_LEN
//  frame_valid  out  1                frame_out/frame_len complete and stable
//  frame_ready  in   1                downstream consumes frame this cycle
// BEHAVIOUR
//  - Reset: state=FILL, cnt=0, frame_valid=0, frame_len=0, all buf slots=PAD_BYTE.
//    in_ready=1 from the first cycle after reset.
//  - Reset mid-FILL or mid-HOLD discards the partial or held frame; there is no
//    frame_valid pulse for it.
//  - FSM, 2 states:
//    FILL: in_ready=1, frame_valid=0.
//      Accept = in_valid & in_ready. On accept: buf[cnt]<=in_byte, cnt<=cnt+1.
//      Close when accept & (in_last | cnt==MSG_LEN-1). On close: frame_len<=cnt+1,
//      go to HOLD.
//    HOLD: in_ready=0, frame_valid=1.
//      in_valid/in_byte/in_last are ignored; no byte is lost, because the source
//      must hold the byte until in_ready.
//      On frame_ready: go to FILL, cnt<=0, all buf slots<=PAD_BYTE, frame_len<=0.
//  - Latency: frame_valid rises the cycle after the closing byte is accepted.
//    in_ready rises the cycle after the frame_ready handshake. This leaves one
//    bubble per frame, which is intended.
//  - frame_out[i] = buf[i]. Slots i>=frame_len read PAD_BYTE because of the clear
//    on reset/consume. frame_out and frame_len must not change while frame_valid=1.
//  - in_last on the MSG_LEN-th byte: one close only, frame_len=MSG_LEN.
//  - A message longer than MSG_LEN auto-closes at MSG_LEN. The remaining bytes
//    start the next frame. No error flag.
//  - cnt width $clog2(MSG_LEN); never exceeds MSG_LEN-1 (no wrap needed).
//  - Empty frames are impossible: in_last is only sampled with an accepted byte.
//  - frame_ready while frame_valid=0 has no effect.
//  - in_last without in_valid has no effect.
// STRUCTURE
//  - Shared package msg_pkg:
//    - localparam MSG_LEN_DEFAULT=9, PAD_SPACE=8'h20
//    - typedef enum logic {FILL, HOLD} asm_state_t
//    - typedef logic [7:0] byte_t
//  - Single flat module; no sub-module warranted.
//  - Encrypt stays combinational downstream. frame_valid gates the register that
//    captures its output.
// TESTING
//  1. Send "PARASCHIV" (9 bytes, in_valid=1 continuously, last on 'V')
//     -> frame_valid=1 the cycle after 'V'; frame_out="PARASCHIV"; frame_len=9.
//  2. Send "HI" with in_last on 'I'
//     -> frame_out="HI"+7x8'h20; frame_len=2; in_ready=0 until frame_ready.
//  3. Hold frame_ready=0 for 5 cycles with in_valid=1 'X'
//     -> frame_out unchanged, in_ready=0, 'X' not captured.
//     Then pulse frame_ready -> next frame starts with 'X' at index 0.
//  4. Send 11 bytes "ABCDEFGHIJK", last on 'K'
//     -> frame1="ABCDEFGHI", len 9; frame2="JK"+7 pads, len 2.
//  5. Assert rst after 4 bytes of "PARASCHIV"; resend "OK"+last
//     -> frame_out="OK"+7 pads, len 2; no earlier frame_valid.
//  6. Gapped in_valid (1 cycle on, 2 off) over "PARASCHIV"
//     -> identical frame to test 1, frame_len=9.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared types and defaults for the message framing front end.
package msg_pkg;

  localparam int unsigned MSG_LEN_DEFAULT = 9;
  localparam logic [7:0]  PAD_SPACE       = 8'h20;

  typedef enum logic {FILL, HOLD} asm_state_t;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/msg_frame_assembler.sv
// Collects a valid/ready byte stream into one MSG_LEN-byte frame, padding short
// messages, and holds the frame until the downstream stage consumes it.
module msg_frame_assembler
  import msg_pkg::*;
#(
  parameter int unsigned MSG_LEN  = MSG_LEN_DEFAULT,
  parameter byte_t       PAD_BYTE = PAD_SPACE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   in_byte,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [7:0]                   frame_out [0:MSG_LEN-1],
  output logic [$clog2(MSG_LEN+1)-1:0] frame_len,
  output logic                         frame_valid,
  input  logic                         frame_ready
);

  localparam int unsigned CW = $clog2(MSG_LEN);
  localparam int unsigned LW = $clog2(MSG_LEN + 1);

  asm_state_t     state_q;
  asm_state_t     state_d;
  logic [CW-1:0]  cnt_q;
  byte_t          slot_q [0:MSG_LEN-1];
  logic           accept;
  logic           close;
  logic           consume;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    frame_valid = 1'b0;
    accept      = 1'b0;
    close       = 1'b0;
    consume     = 1'b0;
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        close    = in_valid & (in_last | (cnt_q == CW'(MSG_LEN - 1)));
        if (close) state_d = HOLD;
      end
      HOLD: begin
        frame_valid = 1'b1;
        consume     = frame_ready;
        if (consume) state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || consume) begin
      cnt_q     <= '0;
      frame_len <= '0;
      for (int unsigned i = 0; i < MSG_LEN; i++) slot_q[i] <= PAD_BYTE;
    end else if (accept) begin
      slot_q[cnt_q] <= in_byte;
      // cnt returns to 0 on close rather than on consume so it never leaves 0..MSG_LEN-1
      cnt_q <= close ? '0 : cnt_q + 1'b1;
      if (close) frame_len <= LW'(cnt_q) + LW'(1);
    end
  end

  assign frame_out = slot_q;

endmodule
